// File: rtl/seq_det_pkg.sv
// ============================================================================
//  Module   : seq_det_pkg
//  Brief    : Shared types and default sizing for the programmable detector.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package seq_det_pkg;

  localparam int c_MAX_LEN = 8;
  localparam int c_CNT_W   = 16;

  typedef enum logic [0:0] {
    UNCFG = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_det_sat_counter.sv
// ============================================================================
//  Module   : seq_det_sat_counter
//  Brief    : Up-counter that sticks at all-ones instead of wrapping.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module seq_det_sat_counter
  import seq_det_pkg::*;
#(
  parameter int CNT_W = c_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/seq_detector_prog.sv
// ============================================================================
//  Module   : seq_detector_prog
//  Brief    : Runtime-programmable serial pattern detector, Mealy match output.
//             Define SEQ_DET_MATCH_COUNT_EN to build the saturating match counter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = c_MAX_LEN,
  parameter int CNT_W   = c_CNT_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in,
  input  logic                           in_valid,
  input  logic                           load,
  input  logic [MAX_LEN-1:0]             pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]   pat_len,
  input  logic                           overlap_en,
  output logic                           out,
  output logic                           cfg_err,
  output logic [CNT_W-1:0]               match_count
);

  localparam int                LEN_W     = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0]  c_LEN_MAX = LEN_W'(MAX_LEN);

  state_t             r_state;
  state_t             w_next_state;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_pat_len;
  logic               r_overlap;
  logic               r_cfg_err;

  logic               w_cfg_ok;
  logic [MAX_LEN:0]   w_window;
  logic [MAX_LEN:0]   w_mask;
  logic               w_pat_eq;
  logic               w_fill_ok;

  assign w_cfg_ok  = (pat_len != '0) && (pat_len <= c_LEN_MAX);
  assign w_window  = {r_hist, in};
  assign w_mask    = ~({(MAX_LEN + 1){1'b1}} << r_pat_len);
  assign w_pat_eq  = ((w_window ^ {1'b0, r_pattern}) & w_mask) == '0;
  // fill >= pat_len-1 rewritten as fill+1 >= pat_len to avoid underflow
  assign w_fill_ok = ({1'b0, r_fill} + (LEN_W + 1)'(1)) >= {1'b0, r_pat_len};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= UNCFG;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (load) begin
      w_next_state = w_cfg_ok ? RUN : UNCFG;
    end
  end

  always_comb begin
    out = (r_state == RUN) && in_valid && !load && w_fill_ok && w_pat_eq;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_pattern <= '0;
      r_pat_len <= '0;
      r_overlap <= 1'b0;
      r_cfg_err <= 1'b0;
    end else if (load) begin
      // A rejected load leaves the old configuration intact but parks in UNCFG
      if (w_cfg_ok) begin
        r_pattern <= pattern;
        r_pat_len <= pat_len;
        r_overlap <= overlap_en;
        r_hist    <= '0;
        r_fill    <= '0;
        r_cfg_err <= 1'b0;
      end else begin
        r_cfg_err <= 1'b1;
      end
    end else if ((r_state == RUN) && in_valid) begin
      r_hist <= {r_hist[MAX_LEN-2:0], in};
      if (out && !r_overlap) begin
        r_fill <= '0;
      end else if (r_fill != c_LEN_MAX) begin
        r_fill <= r_fill + LEN_W'(1);
      end
    end
  end

  assign cfg_err = r_cfg_err;

`ifdef SEQ_DET_MATCH_COUNT_EN
  seq_det_sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out),
    .count (match_count)
  );
`else
  assign match_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_prog.sv
// ============================================================================
//  Module   : tb_seq_detector_prog
//  Brief    : Scoreboard bench for seq_detector_prog against a bit-list model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_detector_prog;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LW      = $clog2(MAX_LEN + 1);
`ifdef SEQ_DET_MATCH_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset, in, in_valid, load, overlap_en;
  logic [MAX_LEN-1:0] pattern;
  logic [LW-1:0]      pat_len;
  logic               out, cfg_err;
  logic [CNT_W-1:0]   match_count;

  seq_detector_prog #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in),
    .in_valid    (in_valid),
    .load        (load),
    .pattern     (pattern),
    .pat_len     (pat_len),
    .overlap_en  (overlap_en),
    .out         (out),
    .cfg_err     (cfg_err),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic out;
    logic err;
    int   cnt;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_no  = 0;

  // Reference model: the received bits since the last (re)start, newest last
  bit               m_run, m_ovl, m_err;
  logic [MAX_LEN-1:0] m_pat;
  int               m_len, m_cnt;
  bit               m_bits[$];

  function automatic bit model_out(bit b, bit v, bit ld);
    int n;
    bit s;
    n = m_bits.size();
    if (!m_run || !v || ld) return 1'b0;
    if (n < m_len - 1) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      s = (k == m_len - 1) ? b : m_bits[n - (m_len - 1) + k];
      if (s != m_pat[m_len - 1 - k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check(input string name, input int c, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, c, act, exp);
    end
  endtask

  task automatic cyc(input bit rst, input bit ld, input logic [MAX_LEN-1:0] pat,
                     input int len, input bit ovl, input bit b, input bit v, input bit chk);
    exp_t e;
    bit   mo;
    @(posedge clk);
    #1;
    reset = rst; load = ld; pattern = pat; pat_len = LW'(len);
    overlap_en = ovl; in = b; in_valid = v;
    mo = model_out(b, v, ld);
    if (chk) begin
      e.cyc = cyc_no; e.out = mo; e.err = m_err; e.cnt = m_cnt;
      q.push_back(e);
    end
    cyc_no++;
    if (rst) begin
      m_run = 0; m_ovl = 0; m_err = 0; m_pat = '0; m_len = 0; m_cnt = 0;
      m_bits.delete();
    end else begin
      if (mo && CNT_EN && (m_cnt < (1 << CNT_W) - 1)) m_cnt++;
      if (ld) begin
        if (len >= 1 && len <= MAX_LEN) begin
          m_pat = pat; m_len = len; m_ovl = ovl; m_err = 0; m_run = 1;
          m_bits.delete();
        end else begin
          m_err = 1; m_run = 0;
        end
      end else if (m_run && v) begin
        if (mo && !m_ovl) begin
          m_bits.delete();
        end else begin
          m_bits.push_back(b);
          if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
        end
      end
    end
  endtask

  task automatic stream(input logic [MAX_LEN-1:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) cyc(0, 0, '0, 0, 0, bits[i], 1, 1);
  endtask

  task automatic do_load(input logic [MAX_LEN-1:0] pat, input int len, input bit ovl);
    cyc(0, 1, pat, len, ovl, 0, 0, 1);
  endtask

  exp_t e_mon;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e_mon = q.pop_front();
      check("out", e_mon.cyc, int'(out), int'(e_mon.out));
      check("cfg_err", e_mon.cyc, int'(cfg_err), int'(e_mon.err));
      check("match_count", e_mon.cyc, int'(match_count), e_mon.cnt);
    end
  end

  initial begin
    int r, len;
    bit rst, ld;
    reset = 1; load = 0; pattern = '0; pat_len = '0; overlap_en = 0; in = 0; in_valid = 0;
    cyc(1, 0, '0, 0, 0, 0, 0, 0);
    cyc(1, 0, '0, 0, 0, 0, 0, 1);
    stream(8'b0000_0111, 3);                   // UNCFG: never matches

    do_load(8'b101, 3, 1); stream(8'b10101, 5); // overlapping
    do_load(8'b101, 3, 0); stream(8'b10101, 5); // non-overlapping
    do_load(8'b101, 3, 1); stream(8'b10, 2);
    repeat (4) cyc(0, 0, '0, 0, 0, 1, 0, 1);
    stream(8'b1, 1);
    do_load(8'b101, 3, 1); stream(8'b10, 2);
    do_load(8'b11, 2, 1); stream(8'b111, 3);
    do_load(8'b1, 0, 1); stream(8'b1111, 4);   // rejected load
    do_load(8'b1, 1, 0); stream(8'b10111, 5);  // single-bit pattern
    do_load(8'b0, 1, 1); stream(8'b00100, 5);
    cyc(0, 1, 8'b11, 2, 1, 1, 1, 1);           // load beats a valid bit
    stream(8'b111, 3);
    stream(8'b1, 1); cyc(1, 0, '0, 0, 0, 1, 1, 1); stream(8'b11, 2);
    do_load(8'b1011_0110, 8, 1); stream(8'b1011_0110, 8); stream(8'b1011_0110, 8);
    do_load(8'b1, 9, 0); stream(8'b11, 2);     // over-length load

    for (int i = 0; i < 4000; i++) begin
      r   = $urandom_range(0, 199);
      rst = (r == 0);
      ld  = (r < 10);
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 3);
      cyc(rst, ld, MAX_LEN'($urandom), len, 1'($urandom), 1'($urandom),
          $urandom_range(0, 3) != 0, 1);
    end

    repeat (3) @(negedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d expected=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
